// File: rtl/layer_input_packer.sv
// rtl/layer_input_packer.sv - packs IN_BITS-wide feature beats into one OUT_W-wide frame
//
// Purpose: collects up to NUM_FEAT feature beats (feature 0 in the LSBs) into a
// frame, then holds the frame until the downstream consumer takes it. Frames
// closed by an early in_last, or by filling the last slot without in_last, are
// still emitted and flagged with a one-cycle frame_err pulse on their first
// out_valid cycle.
//
// Optional feature: define PACKER_ERR_CNT_EN to add err_cnt, a saturating
// 8-bit count of frame_err pulses cleared by rst.
//
// Ports:
//   clk        - clock, all logic on the rising edge
//   rst        - synchronous active-high reset
//   in_data    - one feature beat
//   in_valid   - upstream beat valid
//   in_last    - beat is the final feature of its frame
//   in_ready   - packer accepts a beat this cycle
//   out_data   - packed frame
//   out_valid  - out_data valid
//   out_ready  - downstream consumes the frame
//   err_cnt    - saturating frame_err count (PACKER_ERR_CNT_EN only)
//   frame_err  - one-cycle pulse with the first cycle of a mis-framed frame
module layer_input_packer #(
    parameter int IN_BITS  = 2,
    parameter int NUM_FEAT = 2,
    localparam int OUT_W   = IN_BITS * NUM_FEAT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [IN_BITS-1:0] in_data,
    input  logic               in_valid,
    input  logic               in_last,
    output logic               in_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
`ifdef PACKER_ERR_CNT_EN
    output logic [7:0]         err_cnt,
`endif
    output logic               frame_err
);

    localparam int IDX_W = $clog2(NUM_FEAT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEAT - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t           r_state, w_state_next;
    logic [IDX_W-1:0] r_idx, w_idx_next;
    logic [OUT_W-1:0] r_acc, w_acc_next;
    logic             r_err, w_err_next;
    logic             r_fresh, w_fresh_next;   // first cycle of the held frame

    logic             w_accept;
    logic             w_fire;
    logic [IDX_W-1:0] w_slot;
    logic             w_slot_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= COLLECT;
            r_idx   <= '0;
            r_acc   <= '0;
            r_err   <= 1'b0;
            r_fresh <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_acc   <= w_acc_next;
            r_err   <= w_err_next;
            r_fresh <= w_fresh_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_acc_next   = r_acc;
        w_err_next   = r_err;
        w_fresh_next = 1'b0;

        in_ready  = (r_state == COLLECT) ? 1'b1 : out_ready;
        out_valid = (r_state == HOLD);
        out_data  = r_acc;
        frame_err = (r_state == HOLD) && r_fresh && r_err;

        w_fire   = (r_state == HOLD) && out_ready;
        w_accept = in_valid && in_ready;
        // A beat taken on the handshake cycle starts the next frame at slot 0.
        w_slot      = (r_state == COLLECT) ? r_idx : '0;
        w_slot_last = (w_slot == LAST_IDX);

        if (w_fire) begin
            w_state_next = COLLECT;
            w_idx_next   = '0;
            w_acc_next   = '0;
            w_err_next   = 1'b0;
        end

        if (w_accept) begin
            w_acc_next[w_slot*IN_BITS +: IN_BITS] = in_data;
            if (in_last || w_slot_last) begin
                w_state_next = HOLD;
                w_idx_next   = '0;
                w_fresh_next = 1'b1;
                // Well-formed only when in_last lands exactly on the last slot.
                w_err_next   = !(in_last && w_slot_last);
            end else begin
                w_state_next = COLLECT;
                w_idx_next   = w_slot + 1'b1;
            end
        end
    end

`ifdef PACKER_ERR_CNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (frame_err && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_layer_input_packer.sv
// tb/tb_layer_input_packer.sv - randomized and directed bench for layer_input_packer
module tb_layer_input_packer;

    localparam int IN_BITS  = 2;
    localparam int NUM_FEAT = 2;
    localparam int OUT_W    = IN_BITS * NUM_FEAT;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [IN_BITS-1:0] in_data = '0;
    logic               in_valid = 1'b0;
    logic               in_last = 1'b0;
    logic               in_ready;
    logic [OUT_W-1:0]   out_data;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic               frame_err;
`ifdef PACKER_ERR_CNT_EN
    logic [7:0]         err_cnt;
`endif

    int total = 0;
    int bad   = 0;

    layer_input_packer #(.IN_BITS(IN_BITS), .NUM_FEAT(NUM_FEAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef PACKER_ERR_CNT_EN
        .err_cnt   (err_cnt),
`endif
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a list of beats in the open frame and a queue of
    // completed frames waiting for the consumer.
    typedef struct {
        logic [OUT_W-1:0] data;
        logic             err;
        logic             shown;
    } frame_t;

    logic [IN_BITS-1:0] cur[$];
    frame_t             pend[$];
    int                 m_cnt = 0;

    always @(negedge clk) begin
        logic   exp_valid;
        logic   exp_ready;
        frame_t f;
        exp_valid = (pend.size() != 0);
        exp_ready = exp_valid ? out_ready : 1'b1;
        if (!rst) begin
            chk("model_out_valid", 32'(out_valid), 32'(exp_valid));
            chk("model_in_ready", 32'(in_ready), 32'(exp_ready));
            if (exp_valid) begin
                chk("model_out_data", 32'(out_data), 32'(pend[0].data));
                chk("model_frame_err", 32'(frame_err), 32'(pend[0].err && !pend[0].shown));
            end else begin
                chk("model_frame_err_idle", 32'(frame_err), 32'd0);
            end
`ifdef PACKER_ERR_CNT_EN
            chk("model_err_cnt", 32'(err_cnt), 32'(m_cnt));
`endif
        end
        if (rst) begin
            cur.delete();
            pend.delete();
            m_cnt = 0;
        end else begin
            if (exp_valid) begin
                if (pend[0].err && !pend[0].shown && m_cnt < 255) m_cnt++;
                pend[0].shown = 1'b1;
                if (out_ready) void'(pend.pop_front());
            end
            if (in_valid && exp_ready) begin
                cur.push_back(in_data);
                if (in_last || cur.size() == NUM_FEAT) begin
                    f.data = '0;
                    for (int k = 0; k < cur.size(); k++)
                        f.data = f.data | (OUT_W'(cur[k]) << (k * IN_BITS));
                    f.err   = !(in_last && cur.size() == NUM_FEAT);
                    f.shown = 1'b0;
                    pend.push_back(f);
                    cur.delete();
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b1;        // beat during reset must be ignored
        in_data  = 2'b11;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [IN_BITS-1:0] d, input logic l);
        logic ok;
        ok = 1'b0;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = in_ready;
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;

        // reset state
        do_reset();
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        tick();

        // full frame 11,11(last)
        out_ready = 1'b1;
        send(2'b11, 1'b0);
        send(2'b11, 1'b1);
        @(negedge clk);
        chk("d1_valid", 32'(out_valid), 32'd1);
        chk("d1_data", 32'(out_data), 32'hF);
        chk("d1_err", 32'(frame_err), 32'd0);
        tick();

        // held frame under backpressure
        out_ready = 1'b0;
        send(2'b01, 1'b0);
        send(2'b10, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("d2_hold_valid", 32'(out_valid), 32'd1);
            chk("d2_hold_data", 32'(out_data), 32'h9);
            chk("d2_hold_ready", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("d2_fire_valid", 32'(out_valid), 32'd1);
        tick();
        @(negedge clk);
        chk("d2_once", 32'(out_valid), 32'd0);
        tick();

        // early last: single beat
        do_reset();
        send(2'b10, 1'b1);
        @(negedge clk);
        chk("d3_data", 32'(out_data), 32'h2);
        chk("d3_err", 32'(frame_err), 32'd1);
        tick();
        @(negedge clk);
        chk("d3_err_gone", 32'(frame_err), 32'd0);
`ifdef PACKER_ERR_CNT_EN
        chk("d3_err_cnt", 32'(err_cnt), 32'd1);
`endif
        tick();

        // missing last, then a clean frame
        send(2'b01, 1'b0);
        send(2'b10, 1'b0);
        @(negedge clk);
        chk("d4_data", 32'(out_data), 32'h9);
        chk("d4_err", 32'(frame_err), 32'd1);
        tick();
        send(2'b11, 1'b0);
        send(2'b00, 1'b1);
        @(negedge clk);
        chk("d4b_data", 32'(out_data), 32'h3);
        chk("d4b_err", 32'(frame_err), 32'd0);
        tick();

        // continuous stream, one frame per two cycles
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = IN_BITS'($urandom);
            in_last = i[0];
            @(negedge clk);
            chk("d5_in_ready", 32'(in_ready), 32'd1);
            chk("d5_cadence", 32'(out_valid), 32'((i >= 2) && !i[0]));
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        chk("d5_tail", 32'(out_valid), 32'd1);
        tick();

        // reset discards a partial frame
        send(2'b11, 1'b0);
        do_reset();
        send(2'b00, 1'b0);
        send(2'b01, 1'b1);
        @(negedge clk);
        chk("d6_data", 32'(out_data), 32'h4);
        chk("d6_err", 32'(frame_err), 32'd0);
        tick();

        // counter saturation
        for (int i = 0; i < 300; i++) send(IN_BITS'($urandom), 1'b1);
        tick();
        tick();
`ifdef PACKER_ERR_CNT_EN
        @(negedge clk);
        chk("d6_err_cnt_sat", 32'(err_cnt), 32'd255);
        tick();
`endif

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 199) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = IN_BITS'($urandom);
            in_last   = ($urandom_range(0, 2) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
